dmem_reader: RTL and testbench

Sequential read-out engine for the 16-bit data memory of the vector-encryption CPU. The memory pipeline stage is the writer: it stores results through `memWriteM`/`aluResM`/`writeDataM`. This block is the reader. On a start command it fetches a contiguous block of words through a spare synchronous-read port and streams them out on a valid/ready interface, typically toward a UART or debug host. It absorbs the RAM's one-cycle read latency with a two-entry buffer, so back-pressure never loses or duplicates a word.

---
 rtl/dmem_reader.sv | 162 ++++++++++++++++
 tb/tb_dmem_reader.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_reader.sv
// dmem_reader
//
// Sequential read-out engine for the CPU data memory. On a start command it
// fetches `count` consecutive words beginning at `baseAddr` through a spare
// synchronous-read port and streams them out on a valid/ready interface.
// A two-entry buffer absorbs the one-cycle RAM read latency. Reads are only
// issued when the buffer has room for them, so back-pressure never drops or
// repeats a word.
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   start      one-cycle request, honoured only while idle
//   baseAddr   first word address, captured with start
//   count      number of words (0 .. 2^ADDR_W), captured with start
//   busy       high whenever a transfer is in progress (state != IDLE)
//   done       one-cycle pulse once the final word has been accepted
//   memRe      read strobe to the data-memory read port
//   memAddr    read address, qualified by memRe
//   memRdata   read data, valid the cycle after memRe
//   outValid   stream word available
//   outData    stream word (buffer head)
//   outLast    final word of the transfer, qualified by outValid
//   outReady   consumer accepts the word when outValid && outReady
module dmem_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              memRe,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memRdata,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    output logic              outLast,
    input  logic              outReady
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } stateT;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ZERO = '0;

    stateT             state;
    stateT             stateNext;

    logic [ADDR_W-1:0] addrCnt;
    logic [ADDR_W:0]   issueCnt;
    logic [ADDR_W:0]   deliverCnt;

    logic [DATA_W-1:0] bufMem [2];
    logic              rdPtr;
    logic              wrPtr;
    logic [1:0]        occ;
    logic              inFlight;

    logic              pop;
    logic [1:0]        load;
    logic [1:0]        room;

    // Next state and outputs
    always_comb begin
        stateNext = state;
        outValid  = (occ != 2'd0);
        pop       = outValid && outReady;
        outData   = outValid ? bufMem[rdPtr] : '0;
        outLast   = (deliverCnt == CNT_ONE);
        busy      = (state != IDLE);
        done      = (state == DONE);
        memAddr   = addrCnt;

        // Words held plus words in flight. A word popped this cycle frees its
        // slot at the same edge the new read is launched, so counting the pop
        // keeps the stream at one word per cycle while the total held or in
        // flight after any edge still never exceeds two.
        load  = occ + {1'b0, inFlight};
        room  = 2'd1 + {1'b0, pop};
        memRe = (state == RUN) && (load <= room);

        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = (count == CNT_ZERO) ? DONE : RUN;
                end
            end
            RUN: begin
                if (memRe && (issueCnt == CNT_ONE)) begin
                    stateNext = FLUSH;
                end
            end
            FLUSH: begin
                if (pop && (deliverCnt == CNT_ONE)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // State register, counters and the two-entry buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addrCnt    <= '0;
            issueCnt   <= '0;
            deliverCnt <= '0;
            bufMem[0]  <= '0;
            bufMem[1]  <= '0;
            rdPtr      <= 1'b0;
            wrPtr      <= 1'b0;
            occ        <= '0;
            inFlight   <= 1'b0;
        end else begin
            state    <= stateNext;
            inFlight <= memRe;

            if ((state == IDLE) && start) begin
                addrCnt    <= baseAddr;
                issueCnt   <= count;
                deliverCnt <= count;
            end else begin
                if (memRe) begin
                    addrCnt  <= addrCnt + ADDR_ONE;
                    issueCnt <= issueCnt - CNT_ONE;
                end
                if (pop) begin
                    deliverCnt <= deliverCnt - CNT_ONE;
                end
            end

            // Read data lands one cycle after the strobe; the issue rule
            // guarantees a free slot, so capture is unconditional.
            if (inFlight) begin
                bufMem[wrPtr] <= memRdata;
                wrPtr         <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end

            occ <= occ + {1'b0, inFlight} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_dmem_reader.sv
// Self-checking bench for dmem_reader: a synchronous-read RAM model, a
// reference model built from per-transfer address/data queues, and literal
// expectations for the directed scenarios.
module tb_dmem_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  baseAddr;
    logic [8:0]  count;
    logic        busy;
    logic        done;
    logic        memRe;
    logic [7:0]  memAddr;
    logic [15:0] memRdata;
    logic        outValid;
    logic [15:0] outData;
    logic        outLast;
    logic        outReady;

    dmem_reader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .baseAddr (baseAddr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .memRe    (memRe),
        .memAddr  (memAddr),
        .memRdata (memRdata),
        .outValid (outValid),
        .outData  (outData),
        .outLast  (outLast),
        .outReady (outReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read data memory
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (memRe) memRdata <= mem[memAddr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model state
    logic        mActive = 1'b0;
    logic        doneDueNext = 1'b0;
    logic        zeroNext = 1'b0;
    logic        mThroughput = 1'b0;
    logic        mFirstValid = 1'b0;
    logic        mFirstRe = 1'b0;
    logic        lastStall = 1'b0;
    logic [15:0] stallData = '0;
    logic [7:0]  addrQ [$];
    logic [15:0] dataQ [$];
    int          cyc = 0;
    int          issued = 0;
    int          delivered = 0;

    // Per-transfer logs read by the directed checks
    logic [15:0] gotLog [$];
    logic [7:0]  addrLog [$];
    int          memReCnt = 0;
    int          busyCnt = 0;
    int          lastCnt = 0;
    int          lastIdx = -1;
    int          firstValidCyc = -1;

    logic [1:0]  readyMode = 2'd0;

    always @(negedge clk) begin
        logic expDone;
        logic wasIdle;
        if (rst) begin
            mActive     = 1'b0;
            doneDueNext = 1'b0;
            zeroNext    = 1'b1;
            lastStall   = 1'b0;
            issued      = 0;
            delivered   = 0;
            addrQ.delete();
            dataQ.delete();
        end else begin
            if (zeroNext) begin
                chk("reset_outputs",
                    {3'b0, busy, done, memRe, memAddr, outValid, outData, outLast}, 32'd0);
                zeroNext = 1'b0;
            end
            wasIdle = !mActive;
            if (mActive) cyc++;
            expDone     = doneDueNext;
            doneDueNext = 1'b0;

            chk("busy", busy, mActive);
            chk("done", done, expDone);
            if (busy) busyCnt++;

            if (memRe) begin
                memReCnt++;
                addrLog.push_back(memAddr);
                if (addrQ.size() == 0) begin
                    chk("memRe_unexpected", memRe, 0);
                end else begin
                    chk("memAddr", memAddr, addrQ.pop_front());
                    issued++;
                    if (!mFirstRe) begin
                        chk("first_memRe_cycle", cyc, 1);
                        mFirstRe = 1'b1;
                    end
                end
            end

            if (lastStall) begin
                chk("stall_valid_hold", outValid, 1);
                chk("stall_data_hold", outData, stallData);
            end

            if (outValid) begin
                if (dataQ.size() == 0) begin
                    chk("outValid_unexpected", outValid, 0);
                end else begin
                    if (!mFirstValid) begin
                        chk("first_valid_cycle", cyc, 3);
                        firstValidCyc = cyc;
                        mFirstValid   = 1'b1;
                    end
                    chk("outData", outData, dataQ[0]);
                    chk("outLast", outLast, (dataQ.size() == 1));
                    if (outReady) begin
                        if (outLast) begin
                            lastCnt++;
                            lastIdx = gotLog.size();
                        end
                        gotLog.push_back(outData);
                        void'(dataQ.pop_front());
                        delivered++;
                        if (dataQ.size() == 0) doneDueNext = 1'b1;
                    end
                end
            end else if (mThroughput && mFirstValid && dataQ.size() != 0) begin
                chk("throughput", outValid, 1);
            end

            lastStall = outValid && !outReady;
            stallData = outData;

            if (mActive) chk("outstanding_le2", ((issued - delivered) <= 2), 1);

            if (expDone) mActive = 1'b0;

            if (start && wasIdle) begin
                mActive       = 1'b1;
                cyc           = 0;
                issued        = 0;
                delivered     = 0;
                mFirstValid   = 1'b0;
                mFirstRe      = 1'b0;
                mThroughput   = (readyMode == 2'd0);
                memReCnt      = 0;
                busyCnt       = 0;
                lastCnt       = 0;
                lastIdx       = -1;
                firstValidCyc = -1;
                addrQ.delete();
                dataQ.delete();
                gotLog.delete();
                addrLog.delete();
                for (int i = 0; i < int'(count); i++) begin
                    addrQ.push_back(8'(baseAddr + i));
                    dataQ.push_back(mem[8'(baseAddr + i)]);
                end
                if (count == 9'd0) doneDueNext = 1'b1;
            end
        end
    end

    // Consumer: 0 = always ready, 1 = fixed back-pressure pattern, 2 = random
    initial begin
        int         pIdx;
        logic [1:0] lastMode;
        logic       pat [7];
        pat      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pIdx     = 0;
        lastMode = 2'd0;
        outReady = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (readyMode != lastMode) begin
                pIdx     = 0;
                lastMode = readyMode;
            end
            case (readyMode)
                2'd0: outReady = 1'b1;
                2'd1: begin
                    outReady = pat[pIdx];
                    pIdx     = (pIdx + 1) % 7;
                end
                default: outReady = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic pulseStart(input logic [7:0] b, input logic [8:0] c);
        start    = 1'b1;
        baseAddr = b;
        count    = c;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n;
        n = 0;
        while (mActive && n < maxCyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_within_bound", mActive, 0);
    endtask

    task automatic waitDelivered(input int want, input int maxCyc);
        int n;
        n = 0;
        while (delivered < want && n < maxCyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("delivered_within_bound", (delivered >= want), 1);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  expA [4];
        logic [15:0] expW [4];
        rst      = 1'b1;
        start    = 1'b0;
        baseAddr = '0;
        count    = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic read-out
        mem[0]    = 16'h5678;
        mem[1]    = 16'h5008;
        readyMode = 2'd0;
        pulseStart(8'h00, 9'd2);
        waitIdle(100);
        chk("basic_len", gotLog.size(), 2);
        if (gotLog.size() == 2) begin
            chk("basic_w0", gotLog[0], 16'h5678);
            chk("basic_w1", gotLog[1], 16'h5008);
        end
        chk("basic_memRe_count", memReCnt, 2);
        chk("basic_first_valid", firstValidCyc, 3);
        chk("basic_last_idx", lastIdx, 1);

        // Back-pressure
        for (int i = 0; i < 4; i++) mem[4 + i] = 16'(i + 1);
        readyMode = 2'd1;
        pulseStart(8'h04, 9'd4);
        waitIdle(200);
        chk("bp_len", gotLog.size(), 4);
        if (gotLog.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("bp_word", gotLog[i], i + 1);
        end
        chk("bp_last_idx", lastIdx, 3);

        // Zero count
        readyMode = 2'd0;
        pulseStart(8'h33, 9'd0);
        waitIdle(20);
        chk("zero_memRe_count", memReCnt, 0);
        chk("zero_busy_cycles", busyCnt, 1);
        chk("zero_len", gotLog.size(), 0);

        // Address wrap
        expA = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        expW = '{16'hA0FE, 16'hA0FF, 16'hA000, 16'hA001};
        for (int i = 0; i < 4; i++) mem[expA[i]] = expW[i];
        pulseStart(8'hFE, 9'd4);
        waitIdle(100);
        chk("wrap_addr_len", addrLog.size(), 4);
        chk("wrap_data_len", gotLog.size(), 4);
        if (addrLog.size() == 4 && gotLog.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("wrap_addr", addrLog[i], expA[i]);
                chk("wrap_data", gotLog[i], expW[i]);
            end
        end

        // Full depth with random back-pressure
        readyMode = 2'd2;
        pulseStart(8'($urandom), 9'd256);
        waitIdle(3000);
        chk("full_len", gotLog.size(), 256);
        chk("full_last_idx", lastIdx, 255);
        chk("full_last_count", lastCnt, 1);

        // Protocol robustness: stray start while busy, then reset mid-transfer
        readyMode = 2'd0;
        pulseStart(8'd10, 9'd6);
        pulseStart(8'd99, 9'd3);
        waitDelivered(2, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        pulseStart(8'd20, 9'd5);
        waitIdle(100);
        chk("fresh_len", gotLog.size(), 5);
        if (gotLog.size() == 5) chk("fresh_w4", gotLog[4], mem[24]);
        chk("fresh_last_count", lastCnt, 1);

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            logic [7:0] b;
            logic [8:0] c;
            b = 8'($urandom);
            c = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 40));
            readyMode = 2'($urandom_range(0, 2));
            for (int k = 0; k < 8; k++) mem[8'(b + k)] = 16'($urandom);
            pulseStart(b, c);
            if (c > 9'd4 && (t % 3) == 0) begin
                @(posedge clk); #1;
                pulseStart(8'($urandom), 9'd7);
            end
            waitIdle(600);
            chk("rand_len", gotLog.size(), c);
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
